// File: rtl/pu_pio_arb.sv
// pu_pio_arb: PU register-bus arbiter in front of the PIO decoder.
//
// Two requesters share the PU register bus:
//   m0 = host CSR path, m1 = internal table loader.
// A winning request becomes one bs/rd/wr transaction into the PIO decoder,
// which fans out to the conn_context, switch_info, tag_hash_table and
// tag_value memories. The arbiter waits for the decoder's clk_div-registered
// ack. It then returns read data or an error to the winner, and it aborts the
// access if no ack arrives within TIMEOUT clk_div strobes.
//
// Handshake (requester side):
//   mN_req is a level. The requester holds it until mN_done pulses. mN_wr,
//   mN_addr and mN_wdata are sampled only on the grant cycle, so later
//   changes are ignored. If mN_req drops after grant, the transaction still
//   runs to completion and mN_done still pulses. mN_err and m_rdata are valid
//   in the mN_done cycle. m_rdata then holds until the next completion.
//
// Handshake (decoder side):
//   reg_bs is high from ISSUE through DONE. reg_rd/reg_wr pulse for one clk
//   in ISSUE. pio_ack ends the wait, and pio_rvalid=0 with ack means no target
//   was hit. The decoder must drop pio_ack before the next grant. At most one
//   transaction is outstanding at a time.
//
// Ports:
//   clk, rst_n            core clock, asynchronous active-low reset
//   clk_div               one-clk strobe, decoder update enable
//   m0_*/m1_*             requester interfaces (req, wr, addr, wdata, done, err)
//   m_rdata               shared read-data return
//   reg_bs/wr/rd/addr/din decoder command bus
//   pio_ack/rvalid/rdata  decoder response
//   err_cnt, err_addr     sticky error status (saturating count, last address)
//   dbg_state             current FSM state encoding, for observation only
module pu_pio_arb #(
  parameter int DW      = 32,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clk_div,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_wr,
  input  logic          m1_wr,
  input  logic [DW-1:0] m0_addr,
  input  logic [DW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  output logic          m0_done,
  output logic          m1_done,
  output logic          m0_err,
  output logic          m1_err,
  output logic [DW-1:0] m_rdata,
  output logic          reg_bs,
  output logic          reg_wr,
  output logic          reg_rd,
  output logic [DW-1:0] reg_addr,
  output logic [DW-1:0] reg_din,
  input  logic          pio_ack,
  input  logic          pio_rvalid,
  input  logic [DW-1:0] pio_rdata,
  output logic [7:0]    err_cnt,
  output logic [DW-1:0] err_addr,
  output logic [2:0]    dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ISSUE   = 3'd1,
    S_WAIT    = 3'd2,
    S_DONE    = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic          r_gnt;      // granted master: 0 = m0, 1 = m1
  logic          r_prio;     // master favoured on a simultaneous request
  logic          r_wr;
  logic [DW-1:0] r_addr;
  logic [DW-1:0] r_din;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic [7:0]    r_to_cnt;
  logic [7:0]    r_err_cnt;
  logic [DW-1:0] r_err_addr;

  logic          w_any_req;
  logic          w_grant;
  logic          w_sel;
  logic [7:0]    w_to_inc;
  logic          w_timeout;
  logic          w_wait_exit;

  // Arbitration: a lone requester always wins. On a tie, r_prio decides.
  assign w_any_req = m0_req | m1_req;
  assign w_grant   = (r_state == S_IDLE) && w_any_req && !pio_ack;
  assign w_sel     = (m0_req && m1_req) ? r_prio : !m0_req;

  // The timeout fires on the edge that sees the TIMEOUT-th strobe in WAIT.
  // An ack seen on that same edge takes precedence.
  assign w_to_inc    = r_to_cnt + {7'd0, clk_div};
  assign w_timeout   = clk_div && (w_to_inc == 8'(TIMEOUT));
  assign w_wait_exit = (r_state == S_WAIT) && (pio_ack || w_timeout);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_grant)     w_next = S_ISSUE;
      S_ISSUE:                    w_next = S_WAIT;
      S_WAIT:    if (w_wait_exit) w_next = S_DONE;
      S_DONE:                     w_next = S_RECOVER;
      S_RECOVER: if (!pio_ack)    w_next = S_IDLE;
      default:                    w_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------- grant and latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt  <= 1'b0;
      r_prio <= 1'b0;
      r_wr   <= 1'b0;
      r_addr <= '0;
      r_din  <= '0;
    end else if (w_grant) begin
      r_gnt  <= w_sel;
      r_prio <= !w_sel;
      r_wr   <= w_sel ? m1_wr    : m0_wr;
      r_addr <= w_sel ? m1_addr  : m0_addr;
      r_din  <= w_sel ? m1_wdata : m0_wdata;
    end
  end

  // -------------------------------------------------- strobe counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_to_cnt <= '0;
    end else if (r_state == S_ISSUE) begin
      r_to_cnt <= '0;
    end else if (r_state == S_WAIT && !w_wait_exit) begin
      r_to_cnt <= w_to_inc;
    end
  end

  // ------------------------------------------- response capture at WAIT exit
  // Write data, decode misses and timeouts all return zero on m_rdata.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_wait_exit) begin
      r_err   <= pio_ack ? !pio_rvalid : 1'b1;
      r_rdata <= (pio_ack && pio_rvalid && !r_wr) ? pio_rdata : '0;
    end
  end

  // ------------------------------------------------ sticky error status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt  <= '0;
      r_err_addr <= '0;
    end else if (r_state == S_DONE && r_err) begin
      if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      r_err_addr <= r_addr;
    end
  end

  // ------------------------------------------------------------ outputs
  // Bus controls decode straight from the state, so an asynchronous reset
  // drops reg_bs and the done pulses immediately.
  assign reg_bs    = (r_state == S_ISSUE) || (r_state == S_WAIT) ||
                     (r_state == S_DONE);
  assign reg_wr    = (r_state == S_ISSUE) &&  r_wr;
  assign reg_rd    = (r_state == S_ISSUE) && !r_wr;
  assign reg_addr  = r_addr;
  assign reg_din   = r_din;

  assign m0_done   = (r_state == S_DONE) && !r_gnt;
  assign m1_done   = (r_state == S_DONE) &&  r_gnt;
  assign m0_err    = m0_done && r_err;
  assign m1_err    = m1_done && r_err;
  assign m_rdata   = r_rdata;

  assign err_cnt   = r_err_cnt;
  assign err_addr  = r_err_addr;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pu_pio_arb.sv
// tb_pu_pio_arb: randomized bench for pu_pio_arb with a transaction-level
// reference model (requesters, a PIO decoder responder, and a scoreboard).
module tb_pu_pio_arb;

  localparam int DW = 32;
  localparam int TO = 4;

  // ------------------------------------------------ clock / reset
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          clk_div;
  logic          m0_req, m1_req, m0_wr, m1_wr;
  logic [DW-1:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic          m0_done, m1_done, m0_err, m1_err;
  logic [DW-1:0] m_rdata;
  logic          reg_bs, reg_wr, reg_rd;
  logic [DW-1:0] reg_addr, reg_din;
  logic          pio_ack, pio_rvalid;
  logic [DW-1:0] pio_rdata;
  logic [7:0]    err_cnt;
  logic [DW-1:0] err_addr;
  logic [2:0]    dbg_state;

  pu_pio_arb #(.DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .clk_div(clk_div),
    .m0_req(m0_req), .m1_req(m1_req), .m0_wr(m0_wr), .m1_wr(m1_wr),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_done(m0_done), .m1_done(m1_done), .m0_err(m0_err), .m1_err(m1_err),
    .m_rdata(m_rdata),
    .reg_bs(reg_bs), .reg_wr(reg_wr), .reg_rd(reg_rd),
    .reg_addr(reg_addr), .reg_din(reg_din),
    .pio_ack(pio_ack), .pio_rvalid(pio_rvalid), .pio_rdata(pio_rdata),
    .err_cnt(err_cnt), .err_addr(err_addr), .dbg_state(dbg_state)
  );

  // ------------------------------------------------ scoreboard
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // expected completions: {master, err, rdata}
  logic [DW+1:0] exp_q[$];

  // model state
  logic          prio;           // master favoured on a tie
  logic          in_txn;         // a transaction is on the bus
  logic          cur_g;
  logic [DW-1:0] cur_addr;
  logic          done_due;       // completion expected at this sample
  logic [7:0]    mdl_err_cnt;
  logic [DW-1:0] mdl_err_addr;
  logic [DW-1:0] mdl_rdata;
  int            n_done;
  int            stall;

  // requesters: 0 idle, 1 requesting, 2 granted awaiting done
  int            mst[2];
  int            idle_wait[2];
  logic          keep_req[2];
  logic          d_wr[2];
  logic [DW-1:0] d_addr[2];
  logic [DW-1:0] d_data[2];
  logic          gen_en;

  // decoder responder
  logic          dec_active, dec_skip, dec_ack, dec_rv;
  logic [DW-1:0] dec_rd;
  int            dec_k, dec_cnt, ack_hold, div_pct;
  logic          force_to;

  task automatic new_txn(input int g);
    mst[g]    = 1;
    d_wr[g]   = 1'($urandom_range(0, 1));
    d_addr[g] = $urandom;
    d_data[g] = $urandom;
  endtask

  task automatic drive_masters();
    m0_req   = (mst[0] == 1) || (mst[0] == 2 && keep_req[0]);
    m1_req   = (mst[1] == 1) || (mst[1] == 2 && keep_req[1]);
    m0_wr    = d_wr[0];   m1_wr    = d_wr[1];
    m0_addr  = d_addr[0]; m1_addr  = d_addr[1];
    m0_wdata = d_data[0]; m1_wdata = d_data[1];
  endtask

  // One clock: sample on the falling edge, update the model, drive inputs.
  task automatic step();
    logic          issue_now, due, g;
    logic [DW+1:0] e;
    @(negedge clk);
    issue_now = reg_rd | reg_wr;
    due       = done_due;
    done_due  = 1'b0;
    e         = '0;

    check("m0_done", m0_done, due && !cur_g);
    check("m1_done", m1_done, due &&  cur_g);
    if (due) begin
      if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
      else e = exp_q.pop_front();
      check(cur_g ? "m1_err" : "m0_err", cur_g ? m1_err : m0_err, e[DW]);
      mdl_rdata = e[DW-1:0];
    end
    check("m_rdata", m_rdata, mdl_rdata);
    check("err_cnt", err_cnt, mdl_err_cnt);
    check("err_addr", err_addr, mdl_err_addr);
    check("reg_bs", reg_bs, in_txn || issue_now);

    if (issue_now) begin
      check("overlap", in_txn, 0);
      check("grant_legal", (m0_req | m1_req) & ~pio_ack, 1);
      g = (m0_req && m1_req) ? prio : !m0_req;
      check("reg_addr", reg_addr, d_addr[g]);
      check("reg_din", reg_din, d_data[g]);
      check("reg_wr", reg_wr, d_wr[g]);
      check("reg_rd", reg_rd, !d_wr[g]);
      prio     = !g;
      cur_g    = g;
      cur_addr = d_addr[g];
      in_txn   = 1'b1;
      mst[g]   = 2;
      keep_req[g] = ($urandom_range(0, 3) != 0);
      // decoder response plan for this access
      dec_ack = !force_to && ($urandom_range(0, 9) >= 2);
      dec_rv  = ($urandom_range(0, 3) != 0);
      dec_rd  = $urandom;
      dec_k   = dec_ack ? int'($urandom_range(1, TO)) : TO;
      if (dec_ack)
        exp_q.push_back({g, !dec_rv, (dec_rv && !d_wr[g]) ? dec_rd : {DW{1'b0}}});
      else
        exp_q.push_back({g, 1'b1, {DW{1'b0}}});
      dec_active = 1'b1;
      dec_skip   = 1'b1;
      dec_cnt    = 0;
      // later changes on the granted requester's bus must be ignored
      d_wr[g]   = 1'($urandom_range(0, 1));
      d_addr[g] = $urandom;
      d_data[g] = $urandom;
    end

    if (due) begin
      if (e[DW]) begin
        if (mdl_err_cnt != 8'hFF) mdl_err_cnt = mdl_err_cnt + 8'd1;
        mdl_err_addr = cur_addr;
      end
      in_txn         = 1'b0;
      mst[cur_g]     = 0;
      idle_wait[cur_g] = int'($urandom_range(0, 3));
      ack_hold       = int'($urandom_range(0, 3));
      n_done++;
    end

    // grant watchdog
    if ((m0_req || m1_req) && !in_txn) stall++; else stall = 0;
    if (stall > 40) begin
      check("grant_timeout", reg_bs, 1);
      stall = 0;
    end

    // decoder drive
    clk_div = ($urandom_range(0, 99) < div_pct);
    if (dec_active && !dec_skip && clk_div) dec_cnt++;
    dec_skip = 1'b0;
    if (dec_active && dec_cnt == dec_k) begin
      dec_active = 1'b0;
      done_due   = 1'b1;
      if (dec_ack) begin
        pio_ack    = 1'b1;
        pio_rvalid = dec_rv;
        pio_rdata  = dec_rd;
      end
    end else if (pio_ack) begin
      if (ack_hold > 0) ack_hold--;
      else pio_ack = 1'b0;
    end
    if (!pio_ack) begin
      pio_rvalid = 1'($urandom_range(0, 1));
      pio_rdata  = $urandom;
    end

    // requester drive
    for (int i = 0; i < 2; i++) begin
      if (mst[i] == 0) begin
        if (idle_wait[i] > 0) idle_wait[i]--;
        else if (gen_en) new_txn(i);
      end
    end
    drive_masters();
  endtask

  task automatic run_until(input int target);
    for (int c = 0; c < 20000; c++) begin
      if (n_done >= target) break;
      step();
    end
    check("phase_done", n_done >= target, 1);
  endtask

  task automatic reset_model();
    exp_q.delete();
    prio = 1'b0; in_txn = 1'b0; cur_g = 1'b0; cur_addr = '0; done_due = 1'b0;
    mdl_err_cnt = '0; mdl_err_addr = '0; mdl_rdata = '0; stall = 0;
    dec_active = 1'b0; dec_skip = 1'b0; dec_cnt = 0; ack_hold = 0;
    pio_ack = 1'b0; pio_rvalid = 1'b0; pio_rdata = '0; clk_div = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_reg_bs"}, reg_bs, 0);
    check({tag, "_reg_rdwr"}, {reg_rd, reg_wr}, 0);
    check({tag, "_done"}, {m0_done, m1_done, m0_err, m1_err}, 0);
    check({tag, "_m_rdata"}, m_rdata, 0);
    check({tag, "_reg_addr"}, reg_addr, 0);
    check({tag, "_reg_din"}, reg_din, 0);
    check({tag, "_err_cnt"}, err_cnt, 0);
    check({tag, "_err_addr"}, err_addr, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  // ------------------------------------------------ main sequence
  initial begin
    reset_model();
    n_done = 0; gen_en = 1'b0; force_to = 1'b0; div_pct = 40;
    for (int i = 0; i < 2; i++) begin
      mst[i] = 0; idle_wait[i] = 0; keep_req[i] = 1'b1;
      d_wr[i] = 1'b0; d_addr[i] = '0; d_data[i] = '0;
    end
    drive_masters();
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // mixed reads/writes, acks, misses and timeouts
    gen_en = 1'b1;
    run_until(200);

    // forced timeouts drive the error counter into saturation
    force_to = 1'b1; div_pct = 100;
    run_until(n_done + 300);
    check("err_cnt_sat", err_cnt, 8'hFF);

    // asynchronous reset while a transaction waits for ack
    force_to = 1'b1; div_pct = 30;
    for (int c = 0; c < 200; c++) begin
      if (in_txn && dec_active && dec_cnt >= 1 && !done_due) break;
      step();
    end
    check("reached_wait", dbg_state, 3'd2);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    reset_model();
    force_to = 1'b0; div_pct = 40;
    for (int i = 0; i < 2; i++) begin
      new_txn(i);
      keep_req[i] = 1'b1;
    end
    drive_masters();
    step();
    step();
    rst_n = 1'b1;
    // first grant after reset must go to m0 (checked inside step)
    run_until(n_done + 20);
    gen_en = 1'b0;
    run_until(n_done + 2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
